// File: rtl/store_rmw.sv
// Store path for a memory port without byte enables: places SB/SH/SW data in
// the addressed lanes, using read-modify-write for sub-word stores.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | ready for a request; decode and latch it on transfer
// S_READ  | memRe is high; memory returns the word on the next cycle
// S_MERGE | memRdata is valid; merge the store lanes into it
// S_WRITE | memWe and done are high with the merged word
// S_FAULT | fault is high; the request is dropped without touching memory
module store_rmw #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reqValid,
    output logic              reqReady,
    input  logic [2:0]        storeCtrl,
    input  logic [ADDR_W-1:0] reqAddr,
    input  logic [31:0]       reqData,
    output logic [ADDR_W-1:0] memAddr,
    output logic              memRe,
    input  logic [31:0]       memRdata,
    output logic              memWe,
    output logic [31:0]       memWdata,
    output logic [3:0]        byteEn,
    output logic              done,
    output logic              fault
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_MERGE,
        S_WRITE,
        S_FAULT
    } state_t;

    localparam logic [2:0] CTRL_SB = 3'b000;
    localparam logic [2:0] CTRL_SH = 3'b001;
    localparam logic [2:0] CTRL_SW = 3'b010;

    state_t            state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              mem_re_q, mem_re_d;
    logic              mem_we_q, mem_we_d;
    logic              done_q, done_d;
    logic              fault_q, fault_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        byte_en_q, byte_en_d;
    logic [31:0]       lane_data_q, lane_data_d;

    logic [3:0]        dec_be;
    logic [31:0]       dec_data;
    logic              dec_bad;
    logic              dec_sw;
    logic [31:0]       merged;
    logic              accept;

    // Request decode: lane mask, lane-replicated data and legality.
    always_comb begin
        dec_be   = 4'b0000;
        dec_data = reqData;
        dec_bad  = 1'b1;
        dec_sw   = 1'b0;
        case (storeCtrl)
            CTRL_SB: begin
                dec_be   = 4'b0001 << reqAddr[1:0];
                dec_data = {4{reqData[7:0]}};
                dec_bad  = 1'b0;
            end
            CTRL_SH: begin
                dec_be   = reqAddr[1] ? 4'b1100 : 4'b0011;
                dec_data = {2{reqData[15:0]}};
                dec_bad  = reqAddr[0];
            end
            CTRL_SW: begin
                dec_be   = 4'b1111;
                dec_data = reqData;
                dec_bad  = |reqAddr[1:0];
                dec_sw   = 1'b1;
            end
            default: begin
                dec_be   = 4'b0000;
                dec_bad  = 1'b1;
            end
        endcase
    end

    always_comb begin
        merged = '0;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = byte_en_q[i] ? lane_data_q[8*i +: 8] : memRdata[8*i +: 8];
        end
    end

    // reqReady_q is only ever high in S_IDLE, so it alone qualifies a transfer.
    assign accept = reqValid && req_ready_q;

    // Outputs are computed for the state being entered and then registered.
    always_comb begin
        state_d     = state_q;
        req_ready_d = 1'b0;
        mem_re_d    = 1'b0;
        mem_we_d    = 1'b0;
        done_d      = 1'b0;
        fault_d     = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        byte_en_d   = byte_en_q;
        lane_data_d = lane_data_q;
        case (state_q)
            S_IDLE: begin
                req_ready_d = 1'b1;
                if (accept) begin
                    req_ready_d = 1'b0;
                    mem_addr_d  = {reqAddr[ADDR_W-1:2], 2'b00};
                    byte_en_d   = dec_be;
                    lane_data_d = dec_data;
                    if (dec_bad) begin
                        state_d = S_FAULT;
                        fault_d = 1'b1;
                    end else if (dec_sw) begin
                        state_d     = S_WRITE;
                        mem_we_d    = 1'b1;
                        done_d      = 1'b1;
                        mem_wdata_d = reqData;
                    end else begin
                        state_d  = S_READ;
                        mem_re_d = 1'b1;
                    end
                end
            end
            S_READ: begin
                state_d = S_MERGE;
            end
            S_MERGE: begin
                state_d     = S_WRITE;
                mem_we_d    = 1'b1;
                done_d      = 1'b1;
                mem_wdata_d = merged;
            end
            S_WRITE: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
            end
            S_FAULT: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            byte_en_q   <= '0;
            lane_data_q <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            byte_en_q   <= byte_en_d;
            lane_data_q <= lane_data_d;
        end
    end

    assign reqReady = req_ready_q;
    assign memRe    = mem_re_q;
    assign memWe    = mem_we_q;
    assign done     = done_q;
    assign fault    = fault_q;
    assign memAddr  = mem_addr_q;
    assign memWdata = mem_wdata_q;
    assign byteEn   = byte_en_q;

endmodule

// File: tb/tb_store_rmw.sv
// Directed bench for store_rmw; cycle 1 is the cycle after the accept edge.
module tb_store_rmw;

    logic        clk;
    logic        rst_n;
    logic        reqValid;
    logic        reqReady;
    logic [2:0]  storeCtrl;
    logic [31:0] reqAddr;
    logic [31:0] reqData;
    logic [31:0] memAddr;
    logic        memRe;
    logic [31:0] memRdata;
    logic        memWe;
    logic [31:0] memWdata;
    logic [3:0]  byteEn;
    logic        done;
    logic        fault;

    logic [31:0] rd_word;
    int          passed;
    int          failed;
    int          total;

    store_rmw #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .reqValid  (reqValid),
        .reqReady  (reqReady),
        .storeCtrl (storeCtrl),
        .reqAddr   (reqAddr),
        .reqData   (reqData),
        .memAddr   (memAddr),
        .memRe     (memRe),
        .memRdata  (memRdata),
        .memWe     (memWe),
        .memWdata  (memWdata),
        .byteEn    (byteEn),
        .done      (done),
        .fault     (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory: data only valid the cycle after memRe.
    always @(posedge clk) memRdata <= memRe ? rd_word : 32'hA5A5_A5A5;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, required $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents a request for one accept edge and returns at cycle 1.
    task automatic issue(input logic [2:0] ctrl, input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        reqValid  = 1'b1;
        storeCtrl = ctrl;
        reqAddr   = addr;
        reqData   = data;
        @(negedge clk);
        reqValid  = 1'b0;
        storeCtrl = 3'b111;
        reqAddr   = 32'hFFFF_FFFF;
        reqData   = 32'h0BAD_0BAD;
    endtask

    task automatic sub_store(input string tag, input logic [2:0] ctrl, input logic [31:0] addr,
                             input logic [31:0] data, input logic [31:0] rd,
                             input logic [31:0] exp_addr, input logic [3:0] exp_be,
                             input logic [31:0] exp_wdata);
        rd_word = rd;
        issue(ctrl, addr, data);
        check({tag, " c1 memRe"}, {31'd0, memRe}, 32'd1);
        check({tag, " c1 memWe"}, {31'd0, memWe}, 32'd0);
        check({tag, " c1 reqReady"}, {31'd0, reqReady}, 32'd0);
        @(negedge clk);
        check({tag, " c2 memRe"}, {31'd0, memRe}, 32'd0);
        check({tag, " c2 memWe"}, {31'd0, memWe}, 32'd0);
        @(negedge clk);
        check({tag, " c3 memWe"}, {31'd0, memWe}, 32'd1);
        check({tag, " c3 done"}, {31'd0, done}, 32'd1);
        check({tag, " c3 memAddr"}, memAddr, exp_addr);
        check({tag, " c3 byteEn"}, {28'd0, byteEn}, {28'd0, exp_be});
        check({tag, " c3 memWdata"}, memWdata, exp_wdata);
        check({tag, " c3 reqReady"}, {31'd0, reqReady}, 32'd0);
        @(negedge clk);
        check({tag, " c4 reqReady"}, {31'd0, reqReady}, 32'd1);
        check({tag, " c4 memWe"}, {31'd0, memWe}, 32'd0);
    endtask

    task automatic fault_req(input string tag, input logic [2:0] ctrl, input logic [31:0] addr);
        issue(ctrl, addr, 32'h1234_5678);
        check({tag, " c1 fault"}, {31'd0, fault}, 32'd1);
        check({tag, " c1 memRe"}, {31'd0, memRe}, 32'd0);
        check({tag, " c1 memWe"}, {31'd0, memWe}, 32'd0);
        check({tag, " c1 done"}, {31'd0, done}, 32'd0);
        check({tag, " c1 reqReady"}, {31'd0, reqReady}, 32'd0);
        @(negedge clk);
        check({tag, " c2 reqReady"}, {31'd0, reqReady}, 32'd1);
        check({tag, " c2 fault"}, {31'd0, fault}, 32'd0);
        check({tag, " c2 memRe"}, {31'd0, memRe}, 32'd0);
        check({tag, " c2 memWe"}, {31'd0, memWe}, 32'd0);
    endtask

    initial begin
        passed    = 0;
        failed    = 0;
        total     = 0;
        rst_n     = 1'b0;
        reqValid  = 1'b0;
        storeCtrl = 3'b000;
        reqAddr   = 32'd0;
        reqData   = 32'd0;
        rd_word   = 32'd0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst reqReady", {31'd0, reqReady}, 32'd0);
        check("rst memRe", {31'd0, memRe}, 32'd0);
        check("rst memWe", {31'd0, memWe}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst fault", {31'd0, fault}, 32'd0);
        check("rst memAddr", memAddr, 32'd0);
        check("rst memWdata", memWdata, 32'd0);
        check("rst byteEn", {28'd0, byteEn}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("release reqReady pre-edge", {31'd0, reqReady}, 32'd0);
        @(negedge clk);
        check("release reqReady", {31'd0, reqReady}, 32'd1);

        // Aligned SW
        issue(3'b010, 32'h0000_0100, 32'hDEAD_BEEF);
        check("sw c1 memWe", {31'd0, memWe}, 32'd1);
        check("sw c1 done", {31'd0, done}, 32'd1);
        check("sw c1 memRe", {31'd0, memRe}, 32'd0);
        check("sw c1 memAddr", memAddr, 32'h0000_0100);
        check("sw c1 memWdata", memWdata, 32'hDEAD_BEEF);
        check("sw c1 byteEn", {28'd0, byteEn}, 32'hF);
        check("sw c1 reqReady", {31'd0, reqReady}, 32'd0);
        @(negedge clk);
        check("sw c2 reqReady", {31'd0, reqReady}, 32'd1);
        check("sw c2 memWe", {31'd0, memWe}, 32'd0);
        check("sw c2 memRe", {31'd0, memRe}, 32'd0);

        // Sub-word stores
        sub_store("sb lane2", 3'b000, 32'h0000_0102, 32'h0000_00AB, 32'h1122_3344,
                  32'h0000_0100, 4'b0100, 32'h11AB_3344);
        sub_store("sb lane3", 3'b000, 32'h0000_0103, 32'h0000_00AB, 32'h1122_3344,
                  32'h0000_0100, 4'b1000, 32'hAB22_3344);
        sub_store("sb lane0", 3'b000, 32'h0000_0100, 32'h1234_5678, 32'h1122_3344,
                  32'h0000_0100, 4'b0001, 32'h1122_3378);
        sub_store("sh upper", 3'b001, 32'h0000_0206, 32'h0000_CAFE, 32'h5566_7788,
                  32'h0000_0204, 4'b1100, 32'hCAFE_7788);
        sub_store("sh lower", 3'b001, 32'h0000_0204, 32'hFFFF_CAFE, 32'h5566_7788,
                  32'h0000_0204, 4'b0011, 32'h5566_CAFE);

        // Misaligned and unsupported
        fault_req("sw misaligned", 3'b010, 32'h0000_0101);
        fault_req("ctrl 011", 3'b011, 32'h0000_0100);
        fault_req("sh odd", 3'b001, 32'h0000_0203);

        // Back-pressure: second SB waits behind the first
        rd_word = 32'h1122_3344;
        @(negedge clk);
        reqValid  = 1'b1;
        storeCtrl = 3'b000;
        reqAddr   = 32'h0000_0101;
        reqData   = 32'h0000_0055;
        @(negedge clk);
        reqAddr   = 32'h0000_0302;
        reqData   = 32'h0000_0066;
        check("bp c1 memRe", {31'd0, memRe}, 32'd1);
        check("bp c1 reqReady", {31'd0, reqReady}, 32'd0);
        @(negedge clk);
        check("bp c2 reqReady", {31'd0, reqReady}, 32'd0);
        @(negedge clk);
        check("bp c3 memWe", {31'd0, memWe}, 32'd1);
        check("bp c3 memAddr", memAddr, 32'h0000_0100);
        check("bp c3 memWdata", memWdata, 32'h1122_5544);
        check("bp c3 reqReady", {31'd0, reqReady}, 32'd0);
        @(negedge clk);
        check("bp c4 reqReady", {31'd0, reqReady}, 32'd1);
        check("bp c4 memRe", {31'd0, memRe}, 32'd0);
        @(negedge clk);
        reqValid = 1'b0;
        check("bp c5 memRe", {31'd0, memRe}, 32'd1);
        check("bp c5 memAddr", memAddr, 32'h0000_0300);
        @(negedge clk);
        check("bp c6 memWe", {31'd0, memWe}, 32'd0);
        @(negedge clk);
        check("bp c7 memWe", {31'd0, memWe}, 32'd1);
        check("bp c7 memWdata", memWdata, 32'h1166_3344);
        check("bp c7 byteEn", {28'd0, byteEn}, 32'h4);
        @(negedge clk);
        check("bp c8 reqReady", {31'd0, reqReady}, 32'd1);

        // Reset while in MERGE
        rd_word = 32'h9999_9999;
        issue(3'b000, 32'h0000_0101, 32'h0000_0077);
        check("rstm c1 memRe", {31'd0, memRe}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstm memWe", {31'd0, memWe}, 32'd0);
        check("rstm done", {31'd0, done}, 32'd0);
        check("rstm memRe", {31'd0, memRe}, 32'd0);
        check("rstm reqReady", {31'd0, reqReady}, 32'd0);
        check("rstm memAddr", memAddr, 32'd0);
        check("rstm byteEn", {28'd0, byteEn}, 32'd0);
        check("rstm memWdata", memWdata, 32'd0);
        repeat (2) @(negedge clk);
        check("rstm hold memWe", {31'd0, memWe}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("rstm release pre-edge", {31'd0, reqReady}, 32'd0);
        @(negedge clk);
        check("rstm release reqReady", {31'd0, reqReady}, 32'd1);
        check("rstm release memWe", {31'd0, memWe}, 32'd0);
        @(negedge clk);
        check("rstm idle memWe", {31'd0, memWe}, 32'd0);
        check("rstm idle done", {31'd0, done}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
